// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM states, word-length
// encodings and the per-frame configuration snapshot.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    WLEN_5 = 2'b00,
    WLEN_6 = 2'b01,
    WLEN_7 = 2'b10,
    WLEN_8 = 2'b11
  } wlen_t;

  typedef struct packed {
    wlen_t wlen;
    logic  pen;
    logic  eps;
    logic  sps;
    logic  stp2;
  } tx_cfg_t;

  // Selects the data bits that actually go on the line for a given word length.
  function automatic logic [7:0] wlen_mask(input wlen_t w);
    unique case (w)
      WLEN_5:  return 8'h1F;
      WLEN_6:  return 8'h3F;
      WLEN_7:  return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one character from the TX FIFO and serialises it
// as start, 5-8 data bits LSB-first, optional parity and 1-2 stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       UARTCLK,
  input  logic       UARTRSTn,
  input  logic       baudClk,
  input  logic       uart_en,
  input  logic       tx_en,
  input  logic [1:0] wlen,
  input  logic       pen,
  input  logic       eps,
  input  logic       sps,
  input  logic       stp2,
  input  logic       brk,
  input  logic [7:0] rdata,
  input  logic       rdata_valid,
  output logic       rdata_taken,
  output logic       UARTTXD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  tx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  tx_cfg_t           cfg_q, cfg_d;
  logic              txd_q, txd_d;
  logic              taken_q, taken_d;
  logic              done_q, done_d;

  logic fetch;
  logic bit_end;
  logic last_data;
  logic parity_bit;

  assign fetch     = uart_en & tx_en & rdata_valid & ~brk;
  assign bit_end   = baudClk & (tick_q == TICK_LAST);
  assign last_data = (bit_idx_q == 3'(cfg_q.wlen) + 3'd4);

  // Parity comes from the unshifted copy taken at fetch, masked to the word length.
  assign parity_bit = cfg_q.sps ? ~cfg_q.eps
                                : (^(data_q & wlen_mask(cfg_q.wlen))) ^ ~cfg_q.eps;

  // NOTE: every _d gets its hold value first so no path through the case leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    cfg_d      = cfg_q;
    txd_d      = txd_q;
    taken_d    = 1'b0;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      txd_d  = ~brk;
      tick_d = '0;
      if (fetch) begin
        shift_d    = rdata;
        data_d     = rdata;
        cfg_d.wlen = wlen_t'(wlen);
        cfg_d.pen  = pen;
        cfg_d.eps  = eps;
        cfg_d.sps  = sps;
        cfg_d.stp2 = stp2;
        taken_d    = 1'b1;
        txd_d      = 1'b0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        state_d    = START;
      end
    end else if (baudClk) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    if (bit_end) begin
      unique case (state_q)
        START: begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
        DATA: begin
          if (!last_data) begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end else if (cfg_q.pen) begin
            txd_d   = parity_bit;
            state_d = PARITY;
          end else begin
            txd_d   = 1'b1;
            state_d = STOP;
          end
        end
        PARITY: begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          if (cfg_q.stp2 && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            txd_d   = ~brk;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, matching real hardware.
  always_ff @(posedge UARTCLK or negedge UARTRSTn) begin
    if (!UARTRSTn) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      cfg_q      <= '0;
      txd_q      <= 1'b1;
      taken_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      cfg_q      <= cfg_d;
      txd_q      <= txd_d;
      taken_q    <= taken_d;
      done_q     <= done_d;
    end
  end

  assign rdata_taken = taken_q;
  assign UARTTXD     = txd_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: baudClk every 4 cycles (64 cycles per bit),
// a queue-based FIFO model, and mid-bit sampling of UARTTXD against hand-written frames.
module tb_uart_tx_ctrl;

  logic       UARTCLK     = 1'b0;
  logic       UARTRSTn    = 1'b1;
  logic       baudClk     = 1'b0;
  logic       uart_en     = 1'b1;
  logic       tx_en       = 1'b1;
  logic [1:0] wlen        = 2'b11;
  logic       pen         = 1'b0;
  logic       eps         = 1'b0;
  logic       sps         = 1'b0;
  logic       stp2        = 1'b0;
  logic       brk         = 1'b0;
  logic [7:0] rdata       = 8'h00;
  logic       rdata_valid = 1'b0;
  logic       rdata_taken;
  logic       UARTTXD;
  logic       tx_busy;
  logic       tx_done;

  int         checks = 0;
  int         passes = 0;
  int         pops   = 0;
  logic [1:0] bcnt   = 2'd0;
  logic [7:0] fifo[$];

  uart_tx_ctrl dut (
    .UARTCLK    (UARTCLK),
    .UARTRSTn   (UARTRSTn),
    .baudClk    (baudClk),
    .uart_en    (uart_en),
    .tx_en      (tx_en),
    .wlen       (wlen),
    .pen        (pen),
    .eps        (eps),
    .sps        (sps),
    .stp2       (stp2),
    .brk        (brk),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_taken(rdata_taken),
    .UARTTXD    (UARTTXD),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 UARTCLK = ~UARTCLK;

  always @(negedge UARTCLK) begin
    bcnt    = bcnt + 2'd1;
    baudClk = (bcnt == 2'd3);
  end

  // FIFO read side: pops on rdata_taken, presents the new head half a cycle later.
  always @(negedge UARTCLK) begin
    if (rdata_taken === 1'b1) begin
      pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    rdata_valid = (fifo.size() != 0);
    rdata       = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  task automatic set_cfg(input logic [1:0] w, input logic p, input logic e,
                         input logic s, input logic st);
    wlen = w; pen = p; eps = e; sps = s; stp2 = st;
  endtask

  task automatic wait_taken(output bit ok);
    int w = 0;
    while (rdata_taken !== 1'b1 && w < 400) begin
      @(negedge UARTCLK);
      w++;
    end
    ok = (rdata_taken === 1'b1);
  endtask

  // Expects a fetch, then samples each bit mid-period; exp holds line values, start bit first.
  // mid_op 1 raises brk, mid_op 2 scrambles the configuration during bit 2.
  task automatic check_frame(input string name, input string exp, input int mid_op);
    bit   ok;
    int   cnt;
    int   n;
    logic e;
    n   = exp.len();
    cnt = 0;
    wait_taken(ok);
    checks++;
    if (!ok) begin
      $display("FAIL %s fetch: rdata_taken=%b, required 1 within 400 cycles", name, rdata_taken);
      return;
    end
    passes++;
    for (int k = 0; k < n; k++) begin
      while (cnt < 32 + 64 * k) begin
        @(negedge UARTCLK);
        cnt++;
      end
      if (k == 2 && mid_op == 1) brk = 1'b1;
      if (k == 2 && mid_op == 2) begin
        wlen = 2'b00; pen = 1'b0; stp2 = 1'b0; eps = ~eps;
      end
      e = (exp.getc(k) == "1");
      checks++;
      if (UARTTXD !== e) $display("FAIL %s bit%0d: UARTTXD=%b, required %b", name, k, UARTTXD, e);
      else passes++;
    end
    checks++;
    if (tx_busy !== 1'b1) $display("FAIL %s busy: tx_busy=%b, required 1", name, tx_busy);
    else passes++;
    while (tx_done !== 1'b1 && cnt < 64 * n + 8) begin
      @(negedge UARTCLK);
      cnt++;
    end
    checks++;
    if (tx_done !== 1'b1 || cnt < 64 * n - 3 || cnt > 64 * n)
      $display("FAIL %s done: tx_done=%b at cycle %0d, required 1 at %0d..%0d",
               name, tx_done, cnt, 64 * n - 3, 64 * n);
    else passes++;
  endtask

  // Called on the tx_done cycle: one idle-high cycle, then the next start bit.
  task automatic check_gap(input string name);
    checks++;
    if (UARTTXD !== 1'b1) $display("FAIL %s gap_high: UARTTXD=%b, required 1", name, UARTTXD);
    else passes++;
    @(negedge UARTCLK);
    checks++;
    if (rdata_taken !== 1'b1 || UARTTXD !== 1'b0)
      $display("FAIL %s gap_fetch: rdata_taken=%b UARTTXD=%b, required 1 and 0",
               name, rdata_taken, UARTTXD);
    else passes++;
  endtask

  task automatic test_reset();
    #1 UARTRSTn = 1'b0;
    repeat (3) @(negedge UARTCLK);
    checks++;
    if (UARTTXD !== 1'b1 || tx_busy !== 1'b0 || rdata_taken !== 1'b0 || tx_done !== 1'b0)
      $display("FAIL reset_values: txd=%b busy=%b taken=%b done=%b, required 1 0 0 0",
               UARTTXD, tx_busy, rdata_taken, tx_done);
    else passes++;
    UARTRSTn = 1'b1;
    repeat (20) @(negedge UARTCLK);
    checks++;
    if (UARTTXD !== 1'b1 || tx_busy !== 1'b0 || pops !== 0)
      $display("FAIL idle_empty: txd=%b busy=%b pops=%0d, required 1 0 0", UARTTXD, tx_busy, pops);
    else passes++;
  endtask

  task automatic test_8n1();
    int p0 = pops;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.push_back(8'hAA);
    check_frame("8n1_aa", "0010101011", 0);
    repeat (3) @(negedge UARTCLK);
    checks++;
    if (pops - p0 !== 1 || UARTTXD !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL 8n1_after: pops=%0d txd=%b busy=%b, required 1 1 0", pops - p0, UARTTXD, tx_busy);
    else passes++;
  endtask

  task automatic test_7e2();
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    fifo.push_back(8'h35);
    check_frame("7e2_35", "01010110011", 2);
    repeat (4) @(negedge UARTCLK);
  endtask

  task automatic test_parity();
    set_cfg(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    fifo.push_back(8'h1F);
    check_frame("5o1_1f", "01111101", 0);
    repeat (4) @(negedge UARTCLK);
    set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    fifo.push_back(8'h01);
    check_frame("stick_01", "01000001", 0);
    repeat (4) @(negedge UARTCLK);
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.push_back(8'hAA);
    fifo.push_back(8'hBB);
    fifo.push_back(8'hCC);
    check_frame("b2b_aa", "0010101011", 0);
    check_gap("b2b_ab");
    check_frame("b2b_bb", "0110111011", 0);
    check_gap("b2b_bc");
    check_frame("b2b_cc", "0001100111", 0);
    repeat (3) @(negedge UARTCLK);
    checks++;
    if (pops - p0 !== 3 || tx_busy !== 1'b0)
      $display("FAIL b2b_pops: pops=%0d busy=%b, required 3 0", pops - p0, tx_busy);
    else passes++;
  endtask

  task automatic test_break();
    int p0 = pops;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.push_back(8'h55);
    check_frame("brk_55", "0101010101", 1);
    checks++;
    if (UARTTXD !== 1'b0) $display("FAIL brk_line: UARTTXD=%b, required 0", UARTTXD);
    else passes++;
    fifo.push_back(8'h0F);
    repeat (100) @(negedge UARTCLK);
    checks++;
    if (UARTTXD !== 1'b0 || tx_busy !== 1'b0 || pops - p0 !== 1)
      $display("FAIL brk_hold: txd=%b busy=%b pops=%0d, required 0 0 1", UARTTXD, tx_busy, pops - p0);
    else passes++;
    tx_en = 1'b0;
    brk   = 1'b0;
    repeat (3) @(negedge UARTCLK);
    checks++;
    if (UARTTXD !== 1'b1 || pops - p0 !== 1)
      $display("FAIL brk_release: txd=%b pops=%0d, required 1 1", UARTTXD, pops - p0);
    else passes++;
    tx_en = 1'b1;
    check_frame("after_brk_0f", "0111100001", 0);
    repeat (3) @(negedge UARTCLK);
    checks++;
    if (pops - p0 !== 2) $display("FAIL brk_pops: pops=%0d, required 2", pops - p0);
    else passes++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int p0 = pops;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    fifo.push_back(8'hA5);
    wait_taken(ok);
    repeat (100) @(negedge UARTCLK);
    checks++;
    if (!ok || tx_busy !== 1'b1) $display("FAIL mrst_busy: busy=%b, required 1", tx_busy);
    else passes++;
    UARTRSTn = 1'b0;
    #1;
    checks++;
    if (UARTTXD !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || rdata_taken !== 1'b0)
      $display("FAIL mrst_async: txd=%b busy=%b done=%b taken=%b, required 1 0 0 0",
               UARTTXD, tx_busy, tx_done, rdata_taken);
    else passes++;
    repeat (2) @(negedge UARTCLK);
    UARTRSTn = 1'b1;
    fifo.push_back(8'h3C);
    check_frame("post_rst_3c", "0001111001", 0);
    repeat (3) @(negedge UARTCLK);
    checks++;
    if (pops - p0 !== 2) $display("FAIL mrst_pops: pops=%0d, required 2", pops - p0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_parity();
    test_back_to_back();
    test_break();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
